// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: the central stall/flush sequencer for the 5-stage pipeline.
// It watches ID, EX, the data-memory handshake and branch resolution.
// It drives the PC hold, the IF/ID hold and flush, the ID/EX bubble and flush,
// and the EX/MEM hold.
// The outputs are Mealy: they are decoded from the registered state and the live inputs.
// Optional feature: define HAZARD_PERF_CNT_EN to add three saturating 32-bit
// event counters (perf_lu_cnt, perf_mem_cnt, perf_flush_cnt).
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned FLUSH_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic                      id_ebreak,
  input  logic                      ex_valid,
  input  logic                      ex_is_load,
  input  logic                      ex_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      br_taken,
  input  logic                      mem_busy,
  input  logic                      mem_done,
  output logic                      pc_stall,
  output logic                      ifid_stall,
  output logic                      ifid_flush,
  output logic                      idex_bubble,
  output logic                      idex_flush,
  output logic                      exmem_stall,
  output logic                      halted,
  output logic [2:0]                ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_lu_cnt,
  output logic [31:0]               perf_mem_cnt,
  output logic [31:0]               perf_flush_cnt
`endif
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LU_STALL = 3'd1,
    MEM_WAIT = 3'd2,
    FLUSH    = 3'd3,
    DRAIN    = 3'd4,
    HALT     = 3'd5
  } state_t;

  // Values loaded into the shared down-counter on entry to each multi-cycle state.
  localparam logic [2:0] LU_RELOAD    = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0] FL_RELOAD    = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_RELOAD = 3'd3;
  localparam bit         LU_MULTI     = (LOAD_USE_STALL > 1);
  localparam bit         FL_MULTI     = (FLUSH_CYCLES > 1);

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next, cnt_dec;
  logic       mem_stall, load_use, rs1_hit, rs2_hit;

  // Hazard detection against the instruction currently in EX.
  assign rs1_hit   = id_rs1_used & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit   = id_rs2_used & (id_rs2_addr == ex_rd_addr);
  assign load_use  = id_valid & ex_valid & ex_is_load & ex_reg_wen &
                     (ex_rd_addr != '0) & (rs1_hit | rs2_hit);
  assign mem_stall = mem_busy & ~mem_done;

  // A decrement that saturates at zero, so the counter never wraps.
  assign cnt_dec   = (cnt == '0) ? '0 : cnt - 3'd1;

  assign ctrl_state = state;

  // State and counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic and Mealy output decode.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    halted      = 1'b0;
    case (state)
      // RUN, LU_STALL and FLUSH share one priority chain. A memory stall or a
      // redirect preempts the state's own countdown. An ongoing countdown
      // suppresses new load-use and ebreak detection.
      RUN, LU_STALL, FLUSH: begin
        if (mem_stall) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          exmem_stall = 1'b1;
          state_next  = MEM_WAIT;
        end else if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          cnt_next    = FL_RELOAD;
          state_next  = FL_MULTI ? FLUSH : RUN;
        end else if (state == FLUSH) begin
          ifid_flush  = 1'b1;
          cnt_next    = cnt_dec;
          if (cnt_dec == '0) state_next = RUN;
        end else if (state == LU_STALL) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          cnt_next    = cnt_dec;
          if (cnt_dec == '0) state_next = RUN;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          cnt_next    = LU_RELOAD;
          state_next  = LU_MULTI ? LU_STALL : RUN;
        end else if (id_ebreak) begin
          pc_stall    = 1'b1;
          ifid_flush  = 1'b1;
          cnt_next    = DRAIN_RELOAD;
          state_next  = DRAIN;
        end
      end
      // EX is frozen while MEM waits, so a redirect cannot be taken here.
      MEM_WAIT: begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        exmem_stall = 1'b1;
        if (mem_done) state_next = RUN;
      end
      // DRAIN stays for cnt+1 cycles so that EX, MEM and WB fully retire.
      // A memory stall freezes the countdown.
      DRAIN: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        if (mem_stall) begin
          exmem_stall = 1'b1;
        end else if (cnt == '0) begin
          state_next = HALT;
        end else begin
          cnt_next = cnt - 3'd1;
        end
      end
      HALT: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        halted     = 1'b1;
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic flush_evt;

  // Count only redirect flushes. The standing IF/ID flush during DRAIN and HALT is not counted.
  assign flush_evt = idex_flush | ((state == FLUSH) & ifid_flush);

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_cnt    <= '0;
      perf_mem_cnt   <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (idex_bubble && (perf_lu_cnt != '1))    perf_lu_cnt    <= perf_lu_cnt + 32'd1;
      if (exmem_stall && (perf_mem_cnt != '1))   perf_mem_cnt   <= perf_mem_cnt + 32'd1;
      if (flush_evt && (perf_flush_cnt != '1))   perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl. It applies table vectors, hand-written sequences and
// randomized stimulus to two instances with different parameter sets.
module tb_pipe_hazard_ctrl;

  localparam int unsigned LU1 = 1, FC1 = 2;
  localparam int unsigned LU2 = 3, FC2 = 3;

  typedef struct packed {
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       used1;
    logic       used2;
    logic       ebreak;
    logic       ex_valid;
    logic       ex_is_load;
    logic       ex_reg_wen;
    logic [4:0] rd;
    logic       br;
    logic       busy;
    logic       done;
  } in_t;

  typedef struct {
    string      name;
    in_t        i;
    logic [6:0] exp_out;   // {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush, exmem_stall, halted}
    logic [2:0] exp_next;
  } vec_t;

  // Behavioural model: pending work is held as counters and flags.
  typedef struct {
    int lu_left;
    int flush_left;
    int drain_left;
    bit mem_wait;
    bit drain;
    bit halt;
  } mdl_t;

  logic clk, rst;
  logic id_valid, id_rs1_used, id_rs2_used, id_ebreak;
  logic ex_valid, ex_is_load, ex_reg_wen, br_taken, mem_busy, mem_done;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush, exmem_stall, halted;
  logic pc_stall_b, ifid_stall_b, ifid_flush_b, idex_bubble_b, idex_flush_b, exmem_stall_b, halted_b;
  logic [2:0] ctrl_state, ctrl_state_b;
  logic [6:0] out1, out2;

  int tests, fails;
  mdl_t mdl[2];
  vec_t vecs[16];

  assign out1 = {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_flush, exmem_stall, halted};
  assign out2 = {pc_stall_b, ifid_stall_b, ifid_flush_b, idex_bubble_b, idex_flush_b, exmem_stall_b, halted_b};

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_USE_STALL(LU1), .FLUSH_CYCLES(FC1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_ebreak(id_ebreak), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_reg_wen(ex_reg_wen), .ex_rd_addr(ex_rd_addr), .br_taken(br_taken),
    .mem_busy(mem_busy), .mem_done(mem_done), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .idex_flush(idex_flush), .exmem_stall(exmem_stall), .halted(halted),
    .ctrl_state(ctrl_state));

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_USE_STALL(LU2), .FLUSH_CYCLES(FC2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_ebreak(id_ebreak), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .ex_reg_wen(ex_reg_wen), .ex_rd_addr(ex_rd_addr), .br_taken(br_taken),
    .mem_busy(mem_busy), .mem_done(mem_done), .pc_stall(pc_stall_b),
    .ifid_stall(ifid_stall_b), .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
    .idex_flush(idex_flush_b), .exmem_stall(exmem_stall_b), .halted(halted_b),
    .ctrl_state(ctrl_state_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic in_t mk_in(input logic idv, input logic [4:0] r1, input logic [4:0] r2,
                                input logic u1, input logic u2, input logic eb,
                                input logic exv, input logic ld, input logic wen,
                                input logic [4:0] rd, input logic br, input logic busy,
                                input logic done);
    in_t v;
    v.id_valid = idv; v.rs1 = r1; v.rs2 = r2; v.used1 = u1; v.used2 = u2; v.ebreak = eb;
    v.ex_valid = exv; v.ex_is_load = ld; v.ex_reg_wen = wen; v.rd = rd;
    v.br = br; v.busy = busy; v.done = done;
    return v;
  endfunction

  function automatic vec_t mkv(input string n, input in_t i, input logic [6:0] o, input logic [2:0] s);
    vec_t v;
    v.name = n; v.i = i; v.exp_out = o; v.exp_next = s;
    return v;
  endfunction

  task automatic drive(input in_t v);
    id_valid = v.id_valid; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
    id_rs1_used = v.used1; id_rs2_used = v.used2; id_ebreak = v.ebreak;
    ex_valid = v.ex_valid; ex_is_load = v.ex_is_load; ex_reg_wen = v.ex_reg_wen;
    ex_rd_addr = v.rd; br_taken = v.br; mem_busy = v.busy; mem_done = v.done;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive('0);
    #2;
    rst = 1'b0;
  endtask

  // One cycle of the reference model. It returns the expected outputs and state for
  // the current inputs and advances the pending-work counters unless reset is held.
  function automatic void model_step(input int d, input in_t v, input bit rst_now,
                                     output logic [6:0] o, output logic [2:0] st);
    mdl_t m;
    int lu_n, fc_n;
    bit ms, lu;
    logic pc, is, ifl, bub, xfl, xs, hl;
    lu_n = (d == 0) ? LU1 : LU2;
    fc_n = (d == 0) ? FC1 : FC2;
    if (rst_now) mdl[d] = '{default: 0};
    m = mdl[d];
    ms = v.busy && !v.done;
    lu = v.id_valid && v.ex_valid && v.ex_is_load && v.ex_reg_wen && (v.rd != 0) &&
         ((v.used1 && v.rs1 == v.rd) || (v.used2 && v.rs2 == v.rd));
    {pc, is, ifl, bub, xfl, xs, hl} = '0;
    if (m.halt) st = 3'd5;
    else if (m.mem_wait) st = 3'd2;
    else if (m.drain) st = 3'd4;
    else if (m.flush_left > 0) st = 3'd3;
    else if (m.lu_left > 0) st = 3'd1;
    else st = 3'd0;
    if (m.halt) begin
      pc = 1; ifl = 1; hl = 1;
    end else if (m.mem_wait) begin
      pc = 1; is = 1; xs = 1;
      if (v.done) m.mem_wait = 0;
    end else if (m.drain) begin
      pc = 1; ifl = 1;
      if (ms) xs = 1;
      else if (m.drain_left == 0) begin m.drain = 0; m.halt = 1; end
      else m.drain_left--;
    end else if (ms) begin
      pc = 1; is = 1; xs = 1;
      m.mem_wait = 1; m.lu_left = 0; m.flush_left = 0;
    end else if (v.br) begin
      ifl = 1; xfl = 1;
      m.flush_left = fc_n - 1; m.lu_left = 0;
    end else if (m.flush_left > 0) begin
      ifl = 1; m.flush_left--;
    end else if (m.lu_left > 0) begin
      pc = 1; is = 1; bub = 1; m.lu_left--;
    end else if (lu) begin
      pc = 1; is = 1; bub = 1; m.lu_left = lu_n - 1;
    end else if (v.ebreak) begin
      pc = 1; ifl = 1; m.drain = 1; m.drain_left = 3;
    end
    o = {pc, is, ifl, bub, xfl, xs, hl};
    if (!rst_now) mdl[d] = m;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.id_valid   = ($urandom_range(0, 3) != 0);
    v.rs1        = 5'($urandom_range(0, 3));
    v.rs2        = 5'($urandom_range(0, 3));
    v.used1      = 1'($urandom_range(0, 1));
    v.used2      = 1'($urandom_range(0, 1));
    v.ebreak     = ($urandom_range(0, 39) == 0);
    v.ex_valid   = ($urandom_range(0, 3) != 0);
    v.ex_is_load = 1'($urandom_range(0, 1));
    v.ex_reg_wen = ($urandom_range(0, 3) != 0);
    v.rd         = 5'($urandom_range(0, 3));
    v.br         = ($urandom_range(0, 7) == 0);
    v.busy       = ($urandom_range(0, 5) == 0);
    v.done       = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  initial begin
    in_t lu5, v;
    logic [6:0] eo;
    logic [2:0] es;
    bit r;
    tests = 0;
    fails = 0;
    rst = 1'b0;
    drive('0);

    lu5 = mk_in(1, 5, 0, 1, 0, 0, 1, 1, 1, 5, 0, 0, 0);
    vecs[0]  = mkv("lu_rs1",         lu5,                                             7'b1101000, 3'd0);
    vecs[1]  = mkv("lu_rd0",         mk_in(1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0),  7'b0000000, 3'd0);
    vecs[2]  = mkv("lu_rs2",         mk_in(1, 3, 7, 0, 1, 0, 1, 1, 1, 7, 0, 0, 0),  7'b1101000, 3'd0);
    vecs[3]  = mkv("lu_rs_unused",   mk_in(1, 5, 0, 0, 0, 0, 1, 1, 1, 5, 0, 0, 0),  7'b0000000, 3'd0);
    vecs[4]  = mkv("not_load",       mk_in(1, 5, 0, 1, 0, 0, 1, 0, 1, 5, 0, 0, 0),  7'b0000000, 3'd0);
    vecs[5]  = mkv("no_wen",         mk_in(1, 5, 0, 1, 0, 0, 1, 1, 0, 5, 0, 0, 0),  7'b0000000, 3'd0);
    vecs[6]  = mkv("id_invalid",     mk_in(0, 5, 0, 1, 0, 0, 1, 1, 1, 5, 0, 0, 0),  7'b0000000, 3'd0);
    vecs[7]  = mkv("ex_invalid",     mk_in(1, 5, 0, 1, 0, 0, 0, 1, 1, 5, 0, 0, 0),  7'b0000000, 3'd0);
    vecs[8]  = mkv("br_only",        mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0),  7'b0010100, 3'd3);
    vecs[9]  = mkv("br_over_lu",     mk_in(1, 5, 0, 1, 0, 0, 1, 1, 1, 5, 1, 0, 0),  7'b0010100, 3'd3);
    vecs[10] = mkv("mem_over_br",    mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0),  7'b1100010, 3'd2);
    vecs[11] = mkv("mem_busy_done",  mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1),  7'b0000000, 3'd0);
    vecs[12] = mkv("ebreak",         mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),  7'b1010000, 3'd4);
    vecs[13] = mkv("lu_over_ebreak", mk_in(1, 5, 0, 1, 0, 1, 1, 1, 1, 5, 0, 0, 0),  7'b1101000, 3'd0);
    vecs[14] = mkv("mem_only",       mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0),  7'b1100010, 3'd2);
    vecs[15] = mkv("rs_mismatch",    mk_in(1, 4, 0, 1, 0, 0, 1, 1, 1, 5, 0, 0, 0),  7'b0000000, 3'd0);

    // Reset state.
    rst = 1'b1;
    #1;
    chk("reset_out", 32'(out1), 32'd0);
    chk("reset_state", 32'(ctrl_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle decisions taken from RUN.
    for (int k = 0; k < 16; k++) begin
      do_reset();
      drive(vecs[k].i);
      #1;
      chk({vecs[k].name, "_out"}, 32'(out1), 32'(vecs[k].exp_out));
      @(posedge clk);
      #1;
      chk({vecs[k].name, "_next"}, 32'(ctrl_state), 32'(vecs[k].exp_next));
    end

    // Memory wait: busy for 4 cycles, with done in the 4th cycle.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, (c == 3)));
      #1;
      chk("memwait_out", 32'(out1), 32'b1100010);
      chk("memwait_state", 32'(ctrl_state), (c == 0) ? 32'd0 : 32'd2);
    end
    @(negedge clk);
    drive('0);
    #1;
    chk("memwait_exit_state", 32'(ctrl_state), 32'd0);
    chk("memwait_exit_out", 32'(out1), 32'd0);

    // Redirect with FLUSH_CYCLES=2.
    do_reset();
    @(negedge clk);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    #1;
    chk("redir_c0", 32'(out1), 32'b0010100);
    @(negedge clk);
    drive('0);
    #1;
    chk("redir_c1", 32'(out1), 32'b0010000);
    chk("redir_c1_state", 32'(ctrl_state), 32'd3);
    @(negedge clk);
    #1;
    chk("redir_c2", 32'(out1), 32'd0);
    chk("redir_c2_state", 32'(ctrl_state), 32'd0);

    // Load-use with LOAD_USE_STALL=3 on the second instance.
    do_reset();
    @(negedge clk);
    drive(lu5);
    #1;
    chk("lu3_c0", 32'(out2), 32'b1101000);
    @(negedge clk);
    drive('0);
    for (int c = 1; c < 3; c++) begin
      #1;
      chk("lu3_stall", 32'(out2), 32'b1101000);
      chk("lu3_state", 32'(ctrl_state_b), 32'd1);
      @(negedge clk);
    end
    #1;
    chk("lu3_done", 32'(out2), 32'd0);
    chk("lu3_done_state", 32'(ctrl_state_b), 32'd0);

    // Ebreak: DRAIN for 4 cycles, then HALT is held until reset.
    do_reset();
    @(negedge clk);
    drive(mk_in(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("ebreak_c0", 32'(out1), 32'b1010000);
    @(negedge clk);
    drive('0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("drain_out", 32'(out1), 32'b1010000);
      chk("drain_state", 32'(ctrl_state), 32'd4);
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("halt_out", 32'(out1), 32'b1010001);
      chk("halt_state", 32'(ctrl_state), 32'd5);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("halt_rst_out", 32'(out1), 32'd0);
    chk("halt_rst_state", 32'(ctrl_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-MEM_WAIT, between clock edges.
    do_reset();
    @(negedge clk);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    @(negedge clk);
    #1;
    chk("midrst_pre_state", 32'(ctrl_state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_state", 32'(ctrl_state), 32'd0);
    drive('0);
    #1;
    chk("midrst_out", 32'(out1), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized stimulus against the reference model, on both instances.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r = (n == 0) || ($urandom_range(0, 59) == 0);
      rst = r;
      v = rand_in();
      drive(v);
      #1;
      model_step(0, v, r, eo, es);
      chk("rand_out_a", 32'(out1), 32'(eo));
      chk("rand_state_a", 32'(ctrl_state), 32'(es));
      model_step(1, v, r, eo, es);
      chk("rand_out_b", 32'(out2), 32'(eo));
      chk("rand_state_b", 32'(ctrl_state_b), 32'(es));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID/EX/MEM/WB).
- Watches the instruction in ID, the instruction in EX, the data-memory handshake and branch resolution.
- Drives stall, bubble and flush enables for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers.
- Single owner of pipeline sequencing: replaces per-stage ad-hoc restart signals.

Parameters:
- REG_ADDR_WIDTH, 5, register-file address width.
- LOAD_USE_STALL, 1, bubble cycles inserted for a load-use hazard (1..7).
- FLUSH_CYCLES, 2, cycles IF/ID is held flushed after a redirect, covering instruction-fetch latency (1..7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1_addr  in  REG_ADDR_WIDTH  ID source register 1.
- id_rs2_addr  in  REG_ADDR_WIDTH  ID source register 2.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_ebreak  in  1  ID instruction is ebreak.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load.
- ex_reg_wen  in  1  EX instruction writes rd.
- ex_rd_addr  in  REG_ADDR_WIDTH  EX destination register.
- br_taken  in  1  EX resolved a taken branch/jump/jalr this cycle.
- mem_busy  in  1  MEM data access started, not complete.
- mem_done  in  1  MEM data access completes this cycle.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- idex_flush  out  1  clear ID/EX (redirect).
- exmem_stall  out  1  hold EX/MEM and ID/EX.
- halted  out  1  pipeline drained after ebreak.
- ctrl_state  out  3  current state encoding, for debug.

Behaviour:
- States: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3, DRAIN=4, HALT=5.
- Outputs are Mealy: combinational from state and inputs; state and counters are registered.
- A 3-bit down-counter cnt is shared by LU_STALL, FLUSH and DRAIN.
- Reset (async, any cycle, mid-stall included):
  - state=RUN, cnt=0, halted=0.
  - With inputs at 0, all stall/flush outputs are 0.
- load_use = id_valid & ex_valid & ex_is_load & ex_reg_wen & (ex_rd_addr!=0) & ((id_rs1_used & rs1==rd) | (id_rs2_used & rs2==rd)).
- Priority within a cycle, highest first: mem_busy & !mem_done, then br_taken, then load_use, then id_ebreak.
- RUN:
  - mem stall: pc_stall=ifid_stall=exmem_stall=1; go to MEM_WAIT.
  - br_taken: ifid_flush=idex_flush=1; cnt=FLUSH_CYCLES-1; go to FLUSH if FLUSH_CYCLES>1, else stay in RUN.
  - load_use: pc_stall=ifid_stall=idex_bubble=1; cnt=LOAD_USE_STALL-1; go to LU_STALL if LOAD_USE_STALL>1, else stay in RUN.
    - The load advances to MEM and the hazard clears naturally.
  - id_ebreak with no hazard: pc_stall=1, ifid_flush=1; cnt=3; go to DRAIN.
- LU_STALL:
  - pc_stall=ifid_stall=idex_bubble=1.
  - cnt decrements; return to RUN when cnt==0.
  - br_taken preempts: behave as in RUN.
- MEM_WAIT:
  - pc_stall=ifid_stall=exmem_stall=1 until mem_done.
  - The mem_done cycle still stalls; next state is RUN.
  - br_taken is ignored here, because EX is frozen.
- FLUSH:
  - ifid_flush=1.
  - cnt decrements; return to RUN when cnt==0.
  - A new br_taken reloads cnt; mem stall takes priority.
- DRAIN:
  - pc_stall=1, ifid_flush=1.
  - cnt counts down as EX/MEM/WB empty; a mem stall pauses cnt.
  - At cnt==0 go to HALT.
- HALT: pc_stall=ifid_flush=1, halted=1. Only rst exits.
- Simultaneous mem_busy & mem_done in RUN: no stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_lu_cnt, perf_mem_cnt and perf_flush_cnt, each 32 bits.
  - Each increments on every cycle its stall or flush is asserted.
  - Each saturates at 0xFFFFFFFF and clears on rst.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex load rd=5, ID add rs1=5, LOAD_USE_STALL=1 -> pc_stall/ifid_stall/idex_bubble=1 for exactly 1 cycle; rd=0 gives no stall.
- Memory wait: mem_busy=1 for 4 cycles, mem_done in cycle 4 -> exmem_stall=1 for 4 cycles, ctrl_state=2 then 0.
- Redirect: br_taken pulse, FLUSH_CYCLES=2 -> cycle 0 ifid_flush=idex_flush=1, cycle 1 ifid_flush=1 only, then RUN.
- Priority: br_taken and load_use in the same cycle -> flush only, no idex_bubble; mem_busy with br_taken -> MEM_WAIT.
- Ebreak: id_ebreak=1 -> DRAIN for 4 cycles, then halted=1 held until rst.
- Reset mid-stall: rst asserted during MEM_WAIT -> all outputs 0 and ctrl_state=0 immediately, without waiting for a clock edge.
